seq_alu: RTL
============

Name: seq_alu

Overview:
Parametrised, registered successor to the 4-bit combinational ALU (add/sub/compare/and). Operand width is set by WIDTH, and the operation set adds OR, XOR and a multi-cycle shift-add multiply. The block accepts operations over a valid/ready input handshake and returns registered results and flags over a valid/ready output handshake. It sits between the operand/decoder front end and the result consumer, so the datapath can be pipelined.

Parameters:
WIDTH, 4, operand and result width in bits (legal range 2..32).
OPW, 3, opcode width in bits (fixed at 3; the parameter exists for port sizing only).

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  op, a and b are valid
in_ready  out  1  block accepts the operation this cycle
op  in  OPW  000 ADD, 001 SUB, 010 CMP, 011 AND, 100 OR, 101 XOR, 110 MUL, 111 reserved
a  in  WIDTH  operand A, unsigned
b  in  WIDTH  operand B, unsigned
out_valid  out  1  result and flags are valid
out_ready  in  1  consumer takes the result this cycle
result  out  WIDTH  low result word
result_hi  out  WIDTH  high product word for MUL; 0 for every other op
carry  out  1  ADD: carry-out; SUB: no-borrow (a>=b); 0 for all other ops
lt  out  1  a<b, unsigned, computed on the accepted operands for every op
gt  out  1  a>b, unsigned
eq  out  1  a==b
zero  out  1  {result_hi,result}==0
err  out  1  reserved opcode was accepted

Behaviour:
- Reset: asynchronous on rst_n low, released synchronously to clk. On reset, state=IDLE, out_valid=0, and result, result_hi, carry, lt, gt, eq, zero and err are all 0. in_ready=1 after reset release.
- Reset asserted mid-MUL or mid-DONE aborts the operation and discards the result, with no output.
- Accept: an operation is accepted when in_valid && in_ready at a rising edge; op, a and b are captured.
- FSM states and transitions:
  - IDLE: accept non-MUL -> DONE; accept MUL -> MUL.
  - MUL: iterate, cnt from 0 to WIDTH-1; cnt==WIDTH-1 -> DONE.
  - DONE: out_valid=1. If out_ready, then: a new accept of a non-MUL op stays in DONE; a new accept of a MUL op goes to MUL; no accept goes to IDLE. If !out_ready, hold.
- in_ready = (state==IDLE) || (state==DONE && out_ready). This is a combinational function of state and out_ready and gives back-to-back throughput of 1 op/cycle for non-MUL ops.
- Latency, non-MUL: accepted at edge k -> out_valid high after edge k (available in cycle k+1).
- Latency, MUL: accepted at edge k -> out_valid high after edge k+WIDTH.
- MUL algorithm: shift-add, one partial product per cycle, LSB of b first, 2*WIDTH-bit accumulator. {result_hi,result} = a*b exactly, with no overflow.
- ADD: {carry,result} = a+b, (WIDTH+1)-bit. Wraps modulo 2^WIDTH.
- SUB: result = a + ~b + 1, modulo 2^WIDTH; carry = carry-out of that sum (1 iff a>=b).
- CMP: result = zero-extended {lt,gt,eq} in bits [2:0] (lt=bit2, gt=bit1, eq=bit0); upper bits are 0.
- AND/OR/XOR: bitwise; carry=0.
- Reserved op 111: result=0, result_hi=0, carry=0, err=1. Compare flags are still valid. Latency matches non-MUL ops.
- err is 0 for every legal op.
- Output stability: all outputs hold stable while out_valid && !out_ready. Outputs change only on an accept or on MUL completion.
- Outputs when out_valid=0: don't-care for the consumer, but must not be X after reset.
- in_valid while busy (MUL, or DONE with !out_ready): in_ready=0. The producer holds op/a/b. Nothing is captured.
- Operands are captured at accept only; input changes after accept do not affect the operation in flight.

Test Plan:
- WIDTH=4, reset then ADD a=0001 b=0001, out_ready=1 -> next cycle out_valid=1, result=0010, carry=0, eq=1, zero=0. ADD 1111+0001 -> result=0000, carry=1, zero=1.
- SUB a=1111 b=1101 -> result=0010, carry=1, gt=1. SUB a=0010 b=0101 -> result=1101, carry=0, lt=1.
- CMP a=0110 b=0111 -> result=0100, lt=1, gt=0, eq=0. Follow with AND a=0111 b=0110 back-to-back, in_valid held -> consecutive cycles show result=0100 then 0110, with in_ready=1 throughout.
- MUL a=1111 b=1111, WIDTH=4 -> in_ready=0 for 4 cycles; out_valid after edge k+4; result_hi=1110, result=0001. Repeat at WIDTH=8 with a=0xFF b=0x02 -> result_hi=0x01, result=0xFE, latency 8.
- Backpressure: OR a=1010 b=0101 with out_ready=0 for 5 cycles -> out_valid stays 1, result=1111 held, in_ready=0, a second in_valid is not accepted. Raising out_ready accepts the pending op in the same cycle.
- Op 111 -> err=1, result=0. Asserting rst_n=0 two cycles into a MUL -> out_valid=0 and all outputs 0 immediately. After release, in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result handshake bundle for seq_alu: valid/ready request side
// carrying op/a/b, valid/ready response side carrying result and flags.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] result_hi;
  logic             carry;
  logic             lt;
  logic             gt;
  logic             eq;
  logic             zero;
  logic             err;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, result_hi, carry, lt, gt, eq, zero, err
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, result_hi, carry, lt, gt, eq, zero, err
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshakes: single-cycle add/sub/cmp/logic ops
// and a WIDTH-cycle shift-add multiply producing a 2*WIDTH-bit product.
module seq_alu #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned OPW   = 3
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_CMP = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_MUL = 3'b110,
    OP_RSV = 3'b111
  } op_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result_hi_q, result_hi_d;
  logic               carry_q, carry_d;
  logic               lt_q, lt_d;
  logic               gt_q, gt_d;
  logic               eq_q, eq_d;
  logic               zero_q, zero_d;
  logic               err_q, err_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic [OPW-1:0]     op_in;
  logic               in_ready;
  logic               accept;
  logic [WIDTH:0]     add_w;
  logic [WIDTH:0]     sub_w;
  logic [31:0]        cmp_w;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;
  logic               alu_err;
  logic               is_mul;
  logic               a_lt, a_gt, a_eq;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign op_in    = bus.op;
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept   = bus.in_valid && in_ready;

  // Single-cycle results, evaluated on the operands presented at the port.
  always_comb begin
    a_lt      = bus.a < bus.b;
    a_gt      = bus.a > bus.b;
    a_eq      = bus.a == bus.b;
    add_w     = {1'b0, bus.a} + {1'b0, bus.b};
    sub_w     = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
    cmp_w     = {29'd0, a_lt, a_gt, a_eq};
    alu_res   = '0;
    alu_carry = 1'b0;
    alu_err   = 1'b0;
    is_mul    = 1'b0;
    case (op_t'(op_in))
      OP_ADD: begin
        alu_res   = add_w[WIDTH-1:0];
        alu_carry = add_w[WIDTH];
      end
      OP_SUB: begin
        alu_res   = sub_w[WIDTH-1:0];
        alu_carry = sub_w[WIDTH];
      end
      OP_CMP:  alu_res = cmp_w[WIDTH-1:0];
      OP_AND:  alu_res = bus.a & bus.b;
      OP_OR:   alu_res = bus.a | bus.b;
      OP_XOR:  alu_res = bus.a ^ bus.b;
      OP_MUL:  is_mul  = 1'b1;
      default: alu_err = 1'b1;
    endcase
  end

  // Accumulator holds {partial_hi, remaining multiplier bits}; the multiplier
  // shifts out LSB-first as the partial product shifts in from the top.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next = {mul_sum, acc_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    carry_d     = carry_q;
    lt_d        = lt_q;
    gt_d        = gt_q;
    eq_d        = eq_q;
    zero_d      = zero_q;
    err_d       = err_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    cnt_d       = cnt_q;

    case (state_q)
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          result_d    = mul_next[WIDTH-1:0];
          result_hi_d = mul_next[2*WIDTH-1:WIDTH];
          zero_d      = (mul_next == '0);
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: ;
    endcase

    // Accept is only possible from IDLE or a draining DONE, so it overrides.
    if (accept) begin
      lt_d        = a_lt;
      gt_d        = a_gt;
      eq_d        = a_eq;
      err_d       = alu_err;
      carry_d     = alu_carry;
      result_d    = alu_res;
      result_hi_d = '0;
      zero_d      = (alu_res == '0);
      mcand_d     = bus.a;
      acc_d       = {{WIDTH{1'b0}}, bus.b};
      cnt_d       = '0;
      state_d     = is_mul ? S_MUL : S_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      carry_q     <= 1'b0;
      lt_q        <= 1'b0;
      gt_q        <= 1'b0;
      eq_q        <= 1'b0;
      zero_q      <= 1'b0;
      err_q       <= 1'b0;
      acc_q       <= '0;
      mcand_q     <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      carry_q     <= carry_d;
      lt_q        <= lt_d;
      gt_q        <= gt_d;
      eq_q        <= eq_d;
      zero_q      <= zero_d;
      err_q       <= err_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.result_hi = result_hi_q;
  assign bus.carry     = carry_q;
  assign bus.lt        = lt_q;
  assign bus.gt        = gt_q;
  assign bus.eq        = eq_q;
  assign bus.zero      = zero_q;
  assign bus.err       = err_q;

endmodule
